// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the RegDst mux and the register bank.
// Holds widths, well-known register numbers and the stack-pointer reset value.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;
  localparam int SP_RST   = 227;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  function automatic logic is_zero_reg(input reg_idx_t idx);
    return (idx == reg_idx_t'(REG_ZERO));
  endfunction

endpackage

// File: rtl/reg_bank_chk.sv
// Simulation-only protocol checker for reg_bank: the write address must be known
// whenever reg_write is asserted.
module reg_bank_chk #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input logic              clk,
  input logic              reset,
  input logic              reg_write,
  input logic [ADDR_W-1:0] write_reg
);

  a_write_reg_known: assert property (@(posedge clk) disable iff (!reset)
    reg_write |-> !$isunknown(write_reg));

endmodule

// File: rtl/reg_bank_rdport.sv
// One registered read port of the register bank: register-number mux, r0 forcing
// and optional write-through forwarding (compile with REG_BANK_BYPASS_EN).
module reg_bank_rdport #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               read_en,
  input  logic [ADDR_W-1:0]                  read_reg,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic                               wr_commit,
  input  logic [ADDR_W-1:0]                  write_reg,
  input  logic [DATA_W-1:0]                  write_data,
  output logic [DATA_W-1:0]                  read_data
);
  import mips_pkg::*;

  logic [DATA_W-1:0] sel_data_s;

`ifdef REG_BANK_BYPASS_EN
  // Select the value to capture; a same-cycle committed write to this register is forwarded.
  always_comb begin
    sel_data_s = regs[read_reg];
    if (read_reg == ADDR_W'(REG_ZERO)) begin
      sel_data_s = {DATA_W{1'b0}};
    end else if (wr_commit && (write_reg == read_reg)) begin
      sel_data_s = write_data;
    end else begin
      sel_data_s = regs[read_reg];
    end
  end
`else
  logic bypass_unused_s;
  assign bypass_unused_s = ^{wr_commit, write_reg, write_data};

  // Select the value to capture; the pre-write array contents are returned.
  always_comb begin
    sel_data_s = regs[read_reg];
    if (read_reg == ADDR_W'(REG_ZERO)) begin
      sel_data_s = {DATA_W{1'b0}};
    end else begin
      sel_data_s = regs[read_reg];
    end
  end
`endif

  // Output register: capture on read_en, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= {DATA_W{1'b0}};
    end else if (read_en) begin
      read_data <= sel_data_s;
    end else begin
      read_data <= read_data;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// 32x32 MIPS register file with two registered read ports and one write port.
// Optional same-cycle write-through forwarding is enabled by REG_BANK_BYPASS_EN.
module reg_bank #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int SP_IDX = mips_pkg::REG_SP,
  parameter int SP_RST = mips_pkg::SP_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [7:0]        wr_count
);
  import mips_pkg::*;

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_r;
  logic [7:0]                      wr_count_r;
  logic                            wr_commit_s;

  assign wr_commit_s = reg_write && !is_zero_reg(write_reg);
  assign wr_count    = wr_count_r;

  // Storage array; r0 stays zero because writes to it never commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_r         <= '0;
      regs_r[SP_IDX] <= DATA_W'(SP_RST);
    end else if (wr_commit_s) begin
      regs_r[write_reg] <= write_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Debug count of committed writes, saturating rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count_r <= 8'd0;
    end else if (wr_commit_s && (wr_count_r != 8'hFF)) begin
      wr_count_r <= wr_count_r + 8'd1;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport1 (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .read_reg   (read_reg1),
    .regs       (regs_r),
    .wr_commit  (wr_commit_s),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data  (read_data1)
  );

  reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport2 (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .read_reg   (read_reg2),
    .regs       (regs_r),
    .wr_commit  (wr_commit_s),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data  (read_data2)
  );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a reference model pushes expected port values
// into a scoreboard queue as stimulus is driven; each test pops and compares them.
module tb_reg_bank;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = 5'd0;
  logic [31:0] write_data = 32'd0;
  logic [4:0]  read_reg1 = 5'd0;
  logic [4:0]  read_reg2 = 5'd0;
  logic        read_en = 1'b0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [7:0]  wr_count;

  logic [31:0] mdl [32];
  logic [7:0]  mdl_cnt;
  logic [31:0] held1;
  logic [31:0] held2;
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  reg_bank dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_en    (read_en),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .wr_count   (wr_count)
  );

  reg_bank_chk #(.ADDR_W(5)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .write_reg (write_reg)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl[29] = 32'd227;
    mdl_cnt = 8'd0;
    held1   = 32'd0;
    held2   = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r, input logic commit,
                                             input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
`ifdef REG_BANK_BYPASS_EN
    if (commit && (wr == r)) return wd;
`else
    if (commit && (wr == r) && (wd === 32'hxxxxxxxx)) return 32'd0;
`endif
    return mdl[r];
  endfunction

  // Drive one cycle of stimulus, record the expected outputs, step past the edge.
  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic re, input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    logic commit;
    @(negedge clk);
    reg_write = we; write_reg = wr; write_data = wd;
    read_en = re; read_reg1 = r1; read_reg2 = r2;
    commit = we && (wr != 5'd0);
    if (re) begin
      held1 = model_read(r1, commit, wr, wd);
      held2 = model_read(r2, commit, wr, wd);
    end
    if (commit) begin
      mdl[wr] = wd;
      if (mdl_cnt != 8'hFF) mdl_cnt = mdl_cnt + 8'd1;
    end
    e.rd1 = held1; e.rd2 = held2; e.cnt = mdl_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== 72'd0) begin
      n_errors++;
      $display("FAIL reset_async: got rd1=%h rd2=%h cnt=%0d, expected all zero", read_data1, read_data2, wr_count);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd29);
    e = sb_q.pop_front();
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== {32'd0, 32'd227, 8'd0}) begin
      n_errors++;
      $display("FAIL reset_r0_sp: got rd1=%h rd2=%h cnt=%0d, expected 0/227/0 (sb %h)", read_data1, read_data2, wr_count, e);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd0);
    e = sb_q.pop_front();
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== e) begin
      n_errors++;
      $display("FAIL reset_ra: got rd1=%h rd2=%h cnt=%0d, expected %h", read_data1, read_data2, wr_count, e);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    drive(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    void'(sb_q.pop_front());
    @(negedge clk);
    read_en = 1'b1; read_reg1 = 5'd8; read_reg2 = 5'd8; reg_write = 1'b0;
    #1;
    n_checks++;
    if (read_data1 === 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL write_read_latency: got rd1=%h before the capturing edge", read_data1);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8);
    e = sb_q.pop_front();
    n_checks++;
    if ({read_data1, read_data2} !== {32'hDEADBEEF, 32'hDEADBEEF} || wr_count !== e.cnt) begin
      n_errors++;
      $display("FAIL write_read: got rd1=%h rd2=%h cnt=%0d, expected DEADBEEF x2 cnt=%0d", read_data1, read_data2, wr_count, e.cnt);
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    logic [7:0] cnt0;
    cnt0 = mdl_cnt;
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd0, 32'h87654321, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
    end
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== {32'd0, 32'hDEADBEEF, cnt0}) begin
      n_errors++;
      $display("FAIL zero_reg: got rd1=%h rd2=%h cnt=%0d, expected 0/DEADBEEF cnt=%0d (sb %h)", read_data1, read_data2, wr_count, cnt0, e);
    end
  endtask

  task automatic test_hazard();
    exp_t e;
    logic [31:0] want;
`ifdef REG_BANK_BYPASS_EN
    want = 32'd2;
`else
    want = 32'd1;
`endif
    drive(1'b1, 5'd5, 32'd1, 1'b0, 5'd0, 5'd0);
    void'(sb_q.pop_front());
    drive(1'b1, 5'd5, 32'd2, 1'b1, 5'd5, 5'd0);
    e = sb_q.pop_front();
    n_checks++;
    if (read_data1 !== want || {read_data1, read_data2, wr_count} !== e) begin
      n_errors++;
      $display("FAIL hazard: got rd1=%h rd2=%h cnt=%0d, expected rd1=%h (sb %h)", read_data1, read_data2, wr_count, want, e);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    e = sb_q.pop_front();
    n_checks++;
    if ({read_data1, read_data2} !== {32'd2, 32'd2}) begin
      n_errors++;
      $display("FAIL hazard_after: got rd1=%h rd2=%h, expected 2/2 (sb %h)", read_data1, read_data2, e);
    end
  endtask

  task automatic test_ra_sp();
    exp_t e;
    logic [7:0] cnt0;
    cnt0 = mdl_cnt;
    drive(1'b1, 5'd31, 32'h00400008, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 5'd29, 32'd223, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd29);
    for (int i = 0; i < 3; i++) begin
      e = sb_q.pop_front();
    end
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== {32'h00400008, 32'd223, cnt0 + 8'd2}) begin
      n_errors++;
      $display("FAIL ra_sp: got rd1=%h rd2=%h cnt=%0d, expected 00400008/223 cnt=%0d (sb %h)", read_data1, read_data2, wr_count, cnt0 + 8'd2, e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic we, re;
    logic [4:0] wr, r1, r2;
    logic [31:0] wd;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 3) != 0);
      wr = 5'($urandom_range(0, 31));
      wd = $urandom;
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(we, wr, wd, re, r1, r2);
      e = sb_q.pop_front();
      n_checks++;
      if ({read_data1, read_data2, wr_count} !== e) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got rd1=%h rd2=%h cnt=%0d, expected rd1=%h rd2=%h cnt=%0d", i, read_data1, read_data2, wr_count, e.rd1, e.rd2, e.cnt);
      end
    end
  endtask

  task automatic test_saturate_reset();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 5'((i % 31) + 1), $urandom, (i % 4) == 0, 5'(i % 32), 5'((i + 7) % 32));
      e = sb_q.pop_front();
      n_checks++;
      if ({read_data1, read_data2, wr_count} !== e) begin
        n_errors++;
        $display("FAIL saturate[%0d]: got rd1=%h rd2=%h cnt=%0d, expected rd1=%h rd2=%h cnt=%0d", i, read_data1, read_data2, wr_count, e.rd1, e.rd2, e.cnt);
      end
    end
    drive(1'b1, 5'd29, 32'hCAFE0001, 1'b1, 5'd29, 5'd8);
    e = sb_q.pop_front();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd29);
    e = sb_q.pop_front();
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== {32'hCAFE0001, 32'hCAFE0001, 8'hFF}) begin
      n_errors++;
      $display("FAIL saturate_final: got rd1=%h rd2=%h cnt=%0d, expected CAFE0001 x2 cnt=255 (sb %h)", read_data1, read_data2, wr_count, e);
    end
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd29; write_data = 32'h11111111;
    read_en = 1'b1; read_reg1 = 5'd29; read_reg2 = 5'd29;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== 72'd0) begin
      n_errors++;
      $display("FAIL reset_midop_async: got rd1=%h rd2=%h cnt=%0d, expected all zero", read_data1, read_data2, wr_count);
    end
    @(posedge clk);
    @(negedge clk);
    reg_write = 1'b0; read_en = 1'b0;
    reset = 1'b1;
    model_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd31);
    e = sb_q.pop_front();
    n_checks++;
    if ({read_data1, read_data2, wr_count} !== {32'd227, 32'd0, 8'd0}) begin
      n_errors++;
      $display("FAIL reset_midop_sp: got rd1=%h rd2=%h cnt=%0d, expected 227/0/0 (sb %h)", read_data1, read_data2, wr_count, e);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hazard();
    test_ra_sp();
    test_back_to_back();
    test_saturate_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
